// File: rtl/text_console_pkg.sv
// Shared constants and state encoding for the text console writer.
package text_console_pkg;

    // Default geometry: 640x480 screen, 8x16 glyphs.
    localparam int COLS_DEF   = 80;
    localparam int ROWS_DEF   = 30;
    localparam int ADDR_W_DEF = 12;

    // ASCII codes with special meaning to the writer.
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BLANK = 8'h20;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LINE_CLR = 2'd1,
        ST_SCR_CLR  = 2'd2
    } state_e;

    // True for bytes that produce a glyph in the buffer.
    function automatic logic is_printable(input logic [7:0] ch);
        return (ch >= PRINT_LO) && (ch <= PRINT_HI);
    endfunction

endpackage

// File: rtl/text_console_writer.sv
// Writer side of the character display: consumes an ASCII stream, tracks the
// cursor and issues single-cycle writes into the external character buffer.
module text_console_writer
    import text_console_pkg::*;
#(
    parameter int         COLS   = COLS_DEF,
    parameter int         ROWS   = ROWS_DEF,
    parameter int         ADDR_W = ADDR_W_DEF,
    parameter logic [7:0] BLANK  = CH_BLANK
) (
    input  logic              iClk_50,
    input  logic              nRst,
    input  logic [7:0]        iChar,
    input  logic              iValid,
    output logic              oReady,
    input  logic              iClear,
    output logic              oWrEn,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [7:0]        oWrData,
    output logic [4:0]        oCurRow,
    output logic [6:0]        oCurCol,
    output logic              oBusy
);

    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] SCR_LAST  = ADDR_W'(COLS * ROWS - 1);
    localparam logic [6:0]        COL_LAST  = 7'(COLS - 1);
    localparam logic [4:0]        ROW_LAST  = 5'(ROWS - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] base_q;
    logic [4:0]        row_q;
    logic [6:0]        col_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;

    logic [4:0]        row_adv_d;
    logic [ADDR_W-1:0] base_adv_d;
    logic [ADDR_W-1:0] cur_addr_d;
    logic [ADDR_W-1:0] bs_addr_d;

    // Row/base after a line advance (wrapping to the top), and cursor-derived addresses.
    // The row base is kept incrementally so no multiplier is needed.
    always_comb begin
        if (row_q == ROW_LAST) begin
            row_adv_d  = '0;
            base_adv_d = '0;
        end else begin
            row_adv_d  = row_q + 5'd1;
            base_adv_d = base_q + COLS_A;
        end
        cur_addr_d = base_q + ADDR_W'(col_q);
        bs_addr_d  = cur_addr_d - ADDR_W'(1);
    end

    // Main FSM: byte decode in IDLE, blanking sweeps in LINE_CLR/SCR_CLR, registered write port.
    always_ff @(posedge iClk_50 or negedge nRst) begin
        if (!nRst) begin
            state_q   <= ST_SCR_CLR;
            cnt_q     <= '0;
            base_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (iClear) begin
                        state_q <= ST_SCR_CLR;
                        cnt_q   <= '0;
                    end else if (iValid) begin
                        if (is_printable(iChar)) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= cur_addr_d;
                            wr_data_q <= iChar;
                            if (col_q == COL_LAST) begin
                                col_q   <= '0;
                                row_q   <= row_adv_d;
                                base_q  <= base_adv_d;
                                state_q <= ST_LINE_CLR;
                                cnt_q   <= '0;
                            end else begin
                                col_q <= col_q + 7'd1;
                            end
                        end else begin
                            case (iChar)
                                CH_LF: begin
                                    col_q   <= '0;
                                    row_q   <= row_adv_d;
                                    base_q  <= base_adv_d;
                                    state_q <= ST_LINE_CLR;
                                    cnt_q   <= '0;
                                end
                                CH_CR: col_q <= '0;
                                CH_BS: begin
                                    // Backspace at column 0 never retreats to the previous row.
                                    if (col_q != '0) begin
                                        col_q     <= col_q - 7'd1;
                                        wr_en_q   <= 1'b1;
                                        wr_addr_q <= bs_addr_d;
                                        wr_data_q <= BLANK;
                                    end
                                end
                                CH_FF: begin
                                    state_q <= ST_SCR_CLR;
                                    cnt_q   <= '0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_LINE_CLR: begin
                    // A clear request abandons the line sweep and blanks the whole screen.
                    if (iClear) begin
                        state_q <= ST_SCR_CLR;
                        cnt_q   <= '0;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= base_q + cnt_q;
                        wr_data_q <= BLANK;
                        if (cnt_q == LINE_LAST) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + ADDR_W'(1);
                        end
                    end
                end
                ST_SCR_CLR: begin
                    // Clear requests are ignored here; the sweep always runs to completion.
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= cnt_q;
                    wr_data_q <= BLANK;
                    if (cnt_q == SCR_LAST) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                        base_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign oReady  = (state_q == ST_IDLE) && !iClear;
    assign oBusy   = (state_q != ST_IDLE);
    assign oWrEn   = wr_en_q;
    assign oWrAddr = wr_addr_q;
    assign oWrData = wr_data_q;
    assign oCurRow = row_q;
    assign oCurCol = col_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed testbench for text_console_writer.
module tb_text_console_writer;

    localparam int TOTAL = 2400;

    logic        iClk_50 = 1'b0;
    logic        nRst    = 1'b0;
    logic [7:0]  iChar   = 8'h00;
    logic        iValid  = 1'b0;
    logic        iClear  = 1'b0;
    logic        oReady;
    logic        oWrEn;
    logic [11:0] oWrAddr;
    logic [7:0]  oWrData;
    logic [4:0]  oCurRow;
    logic [6:0]  oCurCol;
    logic        oBusy;

    int tests  = 0;
    int failed = 0;
    int stalls = 0;
    int cyc    = 0;
    int la[$];
    int ld[$];
    int lc[$];

    text_console_writer dut (
        .iClk_50 (iClk_50),
        .nRst    (nRst),
        .iChar   (iChar),
        .iValid  (iValid),
        .oReady  (oReady),
        .iClear  (iClear),
        .oWrEn   (oWrEn),
        .oWrAddr (oWrAddr),
        .oWrData (oWrData),
        .oCurRow (oCurRow),
        .oCurCol (oCurCol),
        .oBusy   (oBusy)
    );

    always #10 iClk_50 = ~iClk_50;

    // Write-port monitor, sampled mid-high phase.
    always @(posedge iClk_50) begin
        cyc++;
        #2;
        if (oWrEn === 1'b1) begin
            la.push_back(int'(oWrAddr));
            ld.push_back(int'(oWrData));
            lc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        la.delete();
        ld.delete();
        lc.delete();
    endtask

    // Offer a byte at the current negedge and hold it until accepted; returns on the next negedge.
    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        iChar  = c;
        iValid = 1'b1;
        #1;
        while (oReady !== 1'b1) begin
            @(negedge iClk_50);
            #1;
            n++;
            stalls++;
            if (n > 5000) begin
                tests++;
                failed++;
                $display("FAIL send_timeout: byte %02h not accepted, expected acceptance", c);
                break;
            end
        end
        @(negedge iClk_50);
    endtask

    task automatic idle();
        iValid = 1'b0;
        iChar  = 8'h00;
    endtask

    // Waits (bounded) for oReady, counting negedges on which it was low.
    task automatic wait_ready(output int low);
        low = 0;
        while (oReady !== 1'b1 && low < 5000) begin
            @(negedge iClk_50);
            low++;
        end
        if (oReady !== 1'b1) begin
            tests++;
            failed++;
            $display("FAIL ready_timeout: oReady=%b, expected 1", oReady);
        end
    endtask

    // Index of the first log entry deviating from a blank sweep base..base+n-1, or -1.
    function automatic int blank_seq_bad(input int first, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            if (first + i >= la.size()) return first + i;
            if (la[first + i] != base + i || ld[first + i] != 32'h20) return first + i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        int low;
        int bad;
        repeat (3) @(negedge iClk_50);
        tests++;
        if (oWrEn !== 1'b0 || oWrAddr !== 12'd0 || oWrData !== 8'd0) begin
            failed++;
            $display("FAIL reset_wr: en=%b addr=%0d data=%02h, expected 0/0/00", oWrEn, oWrAddr, oWrData);
        end
        tests++;
        if (oReady !== 1'b0 || oBusy !== 1'b1) begin
            failed++;
            $display("FAIL reset_flags: ready=%b busy=%b, expected 0/1", oReady, oBusy);
        end
        tests++;
        if (oCurRow !== 5'd0 || oCurCol !== 7'd0) begin
            failed++;
            $display("FAIL reset_cursor: got (%0d,%0d), expected (0,0)", oCurRow, oCurCol);
        end
        clear_log();
        nRst = 1'b1;
        repeat (50) @(negedge iClk_50);
        tests++;
        if (la.size() != 50) begin
            failed++;
            $display("FAIL init_partial: %0d writes, expected 50", la.size());
        end
        // Reset again in the middle of the sweep.
        nRst = 1'b0;
        #1;
        tests++;
        if (oWrEn !== 1'b0 || oWrAddr !== 12'd0 || oBusy !== 1'b1) begin
            failed++;
            $display("FAIL midreset: en=%b addr=%0d busy=%b, expected 0/0/1", oWrEn, oWrAddr, oBusy);
        end
        @(negedge iClk_50);
        clear_log();
        nRst = 1'b1;
        wait_ready(low);
        tests++;
        if (low != TOTAL) begin
            failed++;
            $display("FAIL init_busy_cycles: %0d, expected %0d", low, TOTAL);
        end
        tests++;
        if (la.size() != TOTAL) begin
            failed++;
            $display("FAIL init_writes: %0d, expected %0d", la.size(), TOTAL);
        end
        bad = blank_seq_bad(0, 0, TOTAL);
        tests++;
        if (bad != -1) begin
            failed++;
            $display("FAIL init_seq: first bad entry %0d, expected none", bad);
        end
        tests++;
        if (lc.size() != TOTAL || lc[TOTAL-1] - lc[0] != TOTAL - 1) begin
            failed++;
            $display("FAIL init_consecutive: span %0d, expected %0d", (lc.size() > 1) ? lc[lc.size()-1] - lc[0] : -1, TOTAL - 1);
        end
        tests++;
        if (oCurRow !== 5'd0 || oCurCol !== 7'd0 || oReady !== 1'b1) begin
            failed++;
            $display("FAIL init_done: cursor (%0d,%0d) ready=%b, expected (0,0) 1", oCurRow, oCurCol, oReady);
        end
    endtask

    task automatic test_hi();
        clear_log();
        stalls = 0;
        send(8'h48);
        send(8'h69);
        idle();
        tests++;
        if (la.size() != 2 || la[0] != 0 || ld[0] != 32'h48 || la[1] != 1 || ld[1] != 32'h69) begin
            failed++;
            $display("FAIL hi_writes: n=%0d first=(%0d,%02h), expected n=2 (0,48) (1,69)", la.size(), (la.size() > 0) ? la[0] : -1, (ld.size() > 0) ? ld[0] : -1);
        end
        tests++;
        if (lc.size() != 2 || lc[1] - lc[0] != 1) begin
            failed++;
            $display("FAIL hi_consecutive: writes not on consecutive cycles, expected gap 1");
        end
        tests++;
        if (stalls != 0) begin
            failed++;
            $display("FAIL hi_ready: %0d stall cycles, expected 0", stalls);
        end
        tests++;
        if (oCurRow !== 5'd0 || oCurCol !== 7'd2) begin
            failed++;
            $display("FAIL hi_cursor: got (%0d,%0d), expected (0,2)", oCurRow, oCurCol);
        end
        @(negedge iClk_50);
        tests++;
        if (oWrEn !== 1'b0 || oWrAddr !== 12'd1 || oWrData !== 8'h69) begin
            failed++;
            $display("FAIL hold: en=%b addr=%0d data=%02h, expected 0/1/69", oWrEn, oWrAddr, oWrData);
        end
    endtask

    task automatic test_wrap();
        int low;
        int bad;
        clear_log();
        send(8'h0D);
        idle();
        tests++;
        if (la.size() != 0 || oCurRow !== 5'd0 || oCurCol !== 7'd0) begin
            failed++;
            $display("FAIL cr: writes=%0d cursor (%0d,%0d), expected 0 (0,0)", la.size(), oCurRow, oCurCol);
        end
        clear_log();
        stalls = 0;
        for (int i = 0; i < 80; i++) send(8'h41);
        idle();
        tests++;
        if (stalls != 0) begin
            failed++;
            $display("FAIL wrap_stalls: %0d, expected 0", stalls);
        end
        tests++;
        if (oCurRow !== 5'd1 || oCurCol !== 7'd0 || oReady !== 1'b0 || oBusy !== 1'b1) begin
            failed++;
            $display("FAIL wrap_cursor: (%0d,%0d) ready=%b busy=%b, expected (1,0) 0 1", oCurRow, oCurCol, oReady, oBusy);
        end
        wait_ready(low);
        tests++;
        if (low != 80) begin
            failed++;
            $display("FAIL wrap_busy_cycles: %0d, expected 80", low);
        end
        bad = -1;
        for (int i = 0; i < 80; i++)
            if (bad == -1 && (i >= la.size() || la[i] != i || ld[i] != 32'h41)) bad = i;
        if (bad == -1) bad = blank_seq_bad(80, 80, 80);
        tests++;
        if (bad != -1 || la.size() != 160) begin
            failed++;
            $display("FAIL wrap_seq: first bad %0d n=%0d, expected none n=160", bad, la.size());
        end
        tests++;
        if (lc.size() != 160 || lc[159] - lc[0] != 159) begin
            failed++;
            $display("FAIL wrap_consecutive: writes not back-to-back, expected span 159");
        end
    endtask

    task automatic test_lf_wrap();
        int low;
        int bad;
        for (int i = 0; i < 28; i++) send(8'h0A);
        idle();
        wait_ready(low);
        tests++;
        if (oCurRow !== 5'd29 || oCurCol !== 7'd0) begin
            failed++;
            $display("FAIL row29: got (%0d,%0d), expected (29,0)", oCurRow, oCurCol);
        end
        clear_log();
        send(8'h5A);
        send(8'h0A);
        idle();
        tests++;
        if (oCurRow !== 5'd0 || oCurCol !== 7'd0) begin
            failed++;
            $display("FAIL lf_wrap_cursor: got (%0d,%0d), expected (0,0)", oCurRow, oCurCol);
        end
        wait_ready(low);
        tests++;
        if (la.size() < 1 || la[0] != 2320 || ld[0] != 32'h5A) begin
            failed++;
            $display("FAIL row29_char: got (%0d,%02h), expected (2320,5a)", (la.size() > 0) ? la[0] : -1, (ld.size() > 0) ? ld[0] : -1);
        end
        bad = blank_seq_bad(1, 0, 80);
        tests++;
        if (bad != -1 || la.size() != 81) begin
            failed++;
            $display("FAIL lf_wrap_clr: first bad %0d n=%0d, expected none n=81", bad, la.size());
        end
    endtask

    task automatic test_backspace();
        int low;
        string s;
        s = "abcde";
        for (int i = 0; i < 3; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(s[i]);
        idle();
        tests++;
        if (oCurRow !== 5'd3 || oCurCol !== 7'd5) begin
            failed++;
            $display("FAIL bs_setup: got (%0d,%0d), expected (3,5)", oCurRow, oCurCol);
        end
        clear_log();
        send(8'h08);
        idle();
        @(negedge iClk_50);
        tests++;
        if (la.size() != 1 || la[0] != 244 || ld[0] != 32'h20) begin
            failed++;
            $display("FAIL bs_write: n=%0d addr=%0d, expected n=1 addr=244 data 20", la.size(), (la.size() > 0) ? la[0] : -1);
        end
        tests++;
        if (oCurRow !== 5'd3 || oCurCol !== 7'd4) begin
            failed++;
            $display("FAIL bs_cursor: got (%0d,%0d), expected (3,4)", oCurRow, oCurCol);
        end
        send(8'h0D);
        clear_log();
        send(8'h08);
        send(8'h01);
        send(8'h7F);
        send(8'h1B);
        idle();
        repeat (3) @(negedge iClk_50);
        tests++;
        if (la.size() != 0 || oBusy !== 1'b0) begin
            failed++;
            $display("FAIL bs_col0_ignored: writes=%0d busy=%b, expected 0/0", la.size(), oBusy);
        end
        tests++;
        if (oCurRow !== 5'd3 || oCurCol !== 7'd0) begin
            failed++;
            $display("FAIL bs_col0_cursor: got (%0d,%0d), expected (3,0)", oCurRow, oCurCol);
        end
        wait_ready(low);
    endtask

    task automatic test_clear_in_line();
        int low;
        int bad;
        clear_log();
        send(8'h0A);
        idle();
        repeat (9) @(negedge iClk_50);
        tests++;
        if (la.size() != 9 || la[0] != 320 || la[8] != 328) begin
            failed++;
            $display("FAIL line_clr_start: n=%0d first=%0d, expected n=9 first=320", la.size(), (la.size() > 0) ? la[0] : -1);
        end
        clear_log();
        iClear = 1'b1;
        #1;
        tests++;
        if (oReady !== 1'b0) begin
            failed++;
            $display("FAIL clr_ready: got %b, expected 0", oReady);
        end
        @(negedge iClk_50);
        iClear = 1'b0;
        repeat (99) @(negedge iClk_50);
        // A second request mid-sweep must not restart it.
        iClear = 1'b1;
        @(negedge iClk_50);
        iClear = 1'b0;
        wait_ready(low);
        bad = blank_seq_bad(0, 0, TOTAL);
        tests++;
        if (bad != -1 || la.size() != TOTAL) begin
            failed++;
            $display("FAIL abort_scr_seq: first bad %0d n=%0d, expected none n=%0d", bad, la.size(), TOTAL);
        end
        tests++;
        if (lc.size() != TOTAL || lc[TOTAL-1] - lc[0] != TOTAL - 1) begin
            failed++;
            $display("FAIL abort_scr_consecutive: sweep not contiguous, expected span %0d", TOTAL - 1);
        end
        tests++;
        if (oCurRow !== 5'd0 || oCurCol !== 7'd0) begin
            failed++;
            $display("FAIL abort_cursor: got (%0d,%0d), expected (0,0)", oCurRow, oCurCol);
        end
    endtask

    task automatic test_clear_priority();
        int low;
        int bad;
        send(8'h70);
        idle();
        clear_log();
        iChar  = 8'h58;
        iValid = 1'b1;
        iClear = 1'b1;
        #1;
        tests++;
        if (oReady !== 1'b0) begin
            failed++;
            $display("FAIL prio_ready: got %b, expected 0", oReady);
        end
        @(negedge iClk_50);
        iClear = 1'b0;
        idle();
        tests++;
        if (oWrEn !== 1'b0 || oBusy !== 1'b1 || oCurCol !== 7'd1) begin
            failed++;
            $display("FAIL prio_state: en=%b busy=%b col=%0d, expected 0/1/1", oWrEn, oBusy, oCurCol);
        end
        wait_ready(low);
        bad = blank_seq_bad(0, 0, TOTAL);
        tests++;
        if (bad != -1 || la.size() != TOTAL) begin
            failed++;
            $display("FAIL prio_seq: first bad %0d n=%0d, expected none n=%0d", bad, la.size(), TOTAL);
        end
    endtask

    task automatic test_ff();
        int low;
        int bad;
        send(8'h71);
        clear_log();
        send(8'h0C);
        idle();
        tests++;
        if (oBusy !== 1'b1 || oCurCol !== 7'd1) begin
            failed++;
            $display("FAIL ff_start: busy=%b col=%0d, expected 1/1", oBusy, oCurCol);
        end
        wait_ready(low);
        bad = blank_seq_bad(0, 0, TOTAL);
        tests++;
        if (bad != -1 || la.size() != TOTAL) begin
            failed++;
            $display("FAIL ff_seq: first bad %0d n=%0d, expected none n=%0d", bad, la.size(), TOTAL);
        end
        tests++;
        if (oCurRow !== 5'd0 || oCurCol !== 7'd0) begin
            failed++;
            $display("FAIL ff_cursor: got (%0d,%0d), expected (0,0)", oCurRow, oCurCol);
        end
    endtask

    initial begin
        test_reset();
        test_hi();
        test_wrap();
        test_lf_wrap();
        test_backspace();
        test_clear_in_line();
        test_clear_priority();
        test_ff();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
